icache: RTL and testbench

//  Direct-mapped, blocking instruction cache between iFetch and the memory controller.

---
 rtl/icache_pkg.sv | 13 +
 rtl/icache_line_ram.sv | 54 +++++
 rtl/icache.sv | 132 +++++++++++++
 tb/tb_icache.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared sizing constants and FSM state type for the instruction
// cache. No ports; imported by icache and icache_line_ram.
package icache_pkg;

  localparam int unsigned ICACHE_INDEX_BITS    = 6;  // 64 lines
  localparam int unsigned ICACHE_WORD_OFF_BITS = 2;  // 4 words per line

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_FILL = 1'b1
  } ic_state_e;

endpackage

// File: rtl/icache_line_ram.sv
// icache_line_ram: valid/tag/data arrays of the direct-mapped instruction cache.
// Ports:
//   clk, rst_in          clock, async active-low reset (clears valid bits only)
//   rd_idx               combinational read index
//   rd_valid/tag/line    contents of line rd_idx
//   we, wr_idx, wr_tag,  single-line write: tag and full line written, valid set
//   wr_line
module icache_line_ram
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS    = ICACHE_INDEX_BITS,
  parameter int unsigned WORD_OFF_BITS = ICACHE_WORD_OFF_BITS,
  parameter int unsigned TAG_BITS      = 32 - INDEX_BITS - WORD_OFF_BITS - 2
) (
  input  logic                                  clk,
  input  logic                                  rst_in,
  input  logic [INDEX_BITS-1:0]                 rd_idx,
  output logic                                  rd_valid,
  output logic [TAG_BITS-1:0]                   rd_tag,
  output logic [(2**WORD_OFF_BITS)-1:0][31:0]   rd_line,
  input  logic                                  we,
  input  logic [INDEX_BITS-1:0]                 wr_idx,
  input  logic [TAG_BITS-1:0]                   wr_tag,
  input  logic [(2**WORD_OFF_BITS)-1:0][31:0]   wr_line
);

  localparam int unsigned LINES = 2 ** INDEX_BITS;
  localparam int unsigned WORDS = 2 ** WORD_OFF_BITS;

  logic [LINES-1:0]           valid_q;
  logic [TAG_BITS-1:0]        tag_q  [LINES];
  logic [WORDS-1:0][31:0]     data_q [LINES];

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are never observed while the valid bit is 0.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped, blocking, read-only instruction cache.
// Hits are served combinationally; a miss fetches the whole line from the
// memory controller one word at a time, then the cache returns to serving.
// Ports:
//   clk, rst_in        clock, async active-low reset
//   rdy_in             pause: all state held while low
//   roll_back          ROB flush; an in-progress fill still completes
//   if_addr_in         fetch address (bits [1:0] ignored)
//   if_instr_en_out    hit strobe for if_addr_in this cycle
//   if_instr_out       hit word (0 when no hit)
//   mc_req_out         line-fill request, high for the whole fill
//   mc_addr_out        line base address of the fill
//   mc_word_en_in      fill word valid
//   mc_word_in         fill word, ascending address order
module icache
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS    = ICACHE_INDEX_BITS,
  parameter int unsigned WORD_OFF_BITS = ICACHE_WORD_OFF_BITS
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic [31:0] if_addr_in,
  output logic        if_instr_en_out,
  output logic [31:0] if_instr_out,
  output logic        mc_req_out,
  output logic [31:0] mc_addr_out,
  input  logic        mc_word_en_in,
  input  logic [31:0] mc_word_in
);

  localparam int unsigned TAG_BITS = 32 - INDEX_BITS - WORD_OFF_BITS - 2;
  localparam int unsigned WORDS    = 2 ** WORD_OFF_BITS;
  localparam int unsigned IDX_LSB  = WORD_OFF_BITS + 2;
  localparam int unsigned TAG_LSB  = 32 - TAG_BITS;

  ic_state_e                 state_q, state_d;
  logic [WORD_OFF_BITS-1:0]  word_cnt_q, word_cnt_d;
  logic [31:0]               mc_addr_q, mc_addr_d;
  logic [WORDS-1:0][31:0]    fill_buf_q, fill_buf_d;

  logic [WORD_OFF_BITS-1:0]  if_word;
  logic [INDEX_BITS-1:0]     if_idx;
  logic [TAG_BITS-1:0]       if_tag;

  logic                      rd_valid;
  logic [TAG_BITS-1:0]       rd_tag;
  logic [WORDS-1:0][31:0]    rd_line;
  logic                      tag_match;
  logic                      hit;
  logic                      line_we;

  // Rollback needs no action: the controller cannot abort, so the fill finishes.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, roll_back, if_addr_in[1:0]};

  assign if_word = if_addr_in[IDX_LSB-1:2];
  assign if_idx  = if_addr_in[TAG_LSB-1:IDX_LSB];
  assign if_tag  = if_addr_in[31:TAG_LSB];

  icache_line_ram #(
    .INDEX_BITS    (INDEX_BITS),
    .WORD_OFF_BITS (WORD_OFF_BITS),
    .TAG_BITS      (TAG_BITS)
  ) u_line_ram (
    .clk      (clk),
    .rst_in   (rst_in),
    .rd_idx   (if_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .we       (line_we),
    .wr_idx   (mc_addr_q[TAG_LSB-1:IDX_LSB]),
    .wr_tag   (mc_addr_q[31:TAG_LSB]),
    .wr_line  (fill_buf_d)
  );

  assign tag_match = rd_valid && (rd_tag == if_tag);
  // No hit-under-miss: lookups only count while idle.
  assign hit       = (state_q == IC_IDLE) && tag_match;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    mc_addr_d  = mc_addr_q;
    fill_buf_d = fill_buf_q;
    line_we    = 1'b0;
    unique case (state_q)
      IC_IDLE: begin
        if (!tag_match && rdy_in) begin
          mc_addr_d  = {if_addr_in[31:IDX_LSB], {IDX_LSB{1'b0}}};
          word_cnt_d = '0;
          state_d    = IC_FILL;
        end
      end
      IC_FILL: begin
        if (rdy_in && mc_word_en_in) begin
          fill_buf_d[word_cnt_q] = mc_word_in;
          word_cnt_d             = word_cnt_q + WORD_OFF_BITS'(1);
          // The last word goes to the RAM through fill_buf_d on the same edge.
          if (word_cnt_q == '1) begin
            line_we = 1'b1;
            state_d = IC_IDLE;
          end
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IC_IDLE;
      word_cnt_q <= '0;
      mc_addr_q  <= '0;
      fill_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      mc_addr_q  <= mc_addr_d;
      fill_buf_q <= fill_buf_d;
    end
  end

  assign mc_req_out      = (state_q == IC_FILL);
  assign mc_addr_out     = mc_addr_q;
  assign if_instr_en_out = hit;
  assign if_instr_out    = hit ? rd_line[if_word] : '0;

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed, self-checking bench for icache. A small reference model
// of the line arrays supplies the expected hit/data values; expectations are
// queued when stimulus is applied and popped when the DUT output is sampled.
module tb_icache;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic        roll_back;
  logic [31:0] if_addr_in;
  logic        if_instr_en_out;
  logic [31:0] if_instr_out;
  logic        mc_req_out;
  logic [31:0] mc_addr_out;
  logic        mc_word_en_in;
  logic [31:0] mc_word_in;

  icache #(
    .INDEX_BITS    (6),
    .WORD_OFF_BITS (2)
  ) dut (
    .clk             (clk),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .roll_back       (roll_back),
    .if_addr_in      (if_addr_in),
    .if_instr_en_out (if_instr_en_out),
    .if_instr_out    (if_instr_out),
    .mc_req_out      (mc_req_out),
    .mc_addr_out     (mc_addr_out),
    .mc_word_en_in   (mc_word_en_in),
    .mc_word_in      (mc_word_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the cache contents.
  bit   [63:0] m_valid;
  logic [21:0] m_tag  [64];
  logic [31:0] m_data [64][4];

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sbq[$];

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic push_exp(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    e = sbq.pop_front();
    n_asserts++;
    assert (obs === e.exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    push_exp(tag, exp);
    pop_chk(obs);
  endtask

  // Drive a fetch address and compare the combinational hit path to the model.
  task automatic probe(input string tag, input logic [31:0] addr);
    int unsigned idx;
    bit          hit;
    idx = int'(addr[9:4]);
    if_addr_in = addr;
    #1;
    hit = m_valid[idx] && (m_tag[idx] == addr[31:10]);
    push_exp({tag, "_en"}, {31'b0, hit});
    push_exp({tag, "_data"}, hit ? m_data[idx][addr[3:2]] : 32'h0);
    pop_chk({31'b0, if_instr_en_out});
    pop_chk(if_instr_out);
  endtask

  // Miss on addr, serve the line; optional rollback from word rb_at on and an
  // rdy_in=0 stall (with a junk word offered) just before word stall_at.
  task automatic do_fill(input logic [31:0] addr, input logic [3:0][31:0] ws,
                         input int rb_at, input int stall_at);
    logic [31:0] base;
    int unsigned idx;
    base = {addr[31:4], 4'h0};
    idx  = int'(addr[9:4]);
    @(negedge clk);
    rdy_in = 1'b1;
    probe("fill_miss", addr);
    @(negedge clk);
    #1;
    expect_now("fill_req", {31'b0, mc_req_out}, 32'd1);
    expect_now("fill_addr", mc_addr_out, base);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i == stall_at) begin
        rdy_in        = 1'b0;
        mc_word_en_in = 1'b1;
        mc_word_in    = 32'hDEAD_BEEF;
        #1;
        expect_now("stall_req", {31'b0, mc_req_out}, 32'd1);
        @(negedge clk);
        rdy_in = 1'b1;
      end
      if (rb_at >= 0 && i >= rb_at) begin
        roll_back  = 1'b1;
        if_addr_in = 32'h0000_0404;
      end
      mc_word_en_in = 1'b1;
      mc_word_in    = ws[i];
      #1;
      expect_now("fill_no_hit", {31'b0, if_instr_en_out}, 32'd0);
      @(negedge clk);
    end
    mc_word_en_in = 1'b0;
    roll_back     = 1'b0;
    rdy_in        = 1'b0;
    m_valid[idx]  = 1'b1;
    m_tag[idx]    = addr[31:10];
    for (int w = 0; w < 4; w++) m_data[idx][w] = ws[w];
    #1;
    expect_now("fill_done_req", {31'b0, mc_req_out}, 32'd0);
    probe("refetch", addr);
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    m_valid       = '0;
    rst_in        = 1'b0;
    rdy_in        = 1'b0;
    roll_back     = 1'b0;
    if_addr_in    = 32'h0;
    mc_word_en_in = 1'b0;
    mc_word_in    = 32'h0;

    // Reset values
    @(negedge clk);
    #1;
    expect_now("rst_req", {31'b0, mc_req_out}, 32'd0);
    expect_now("rst_maddr", mc_addr_out, 32'h0);
    expect_now("rst_en", {31'b0, if_instr_en_out}, 32'd0);
    expect_now("rst_instr", if_instr_out, 32'h0);
    @(negedge clk);
    rst_in = 1'b1;

    // Fill line 0 and read back every word
    do_fill(32'h0000_0000, {32'h44, 32'h33, 32'h22, 32'h11}, -1, -1);
    probe("hit_w2", 32'h0000_0008);
    probe("hit_w0", 32'h0000_0000);
    probe("hit_w3_lowbits", 32'h0000_000F);

    // mc_word_en_in and roll_back while idle are ignored
    @(negedge clk);
    rdy_in        = 1'b1;
    if_addr_in    = 32'h0000_0008;
    mc_word_en_in = 1'b1;
    mc_word_in    = 32'h0000_0BAD;
    roll_back     = 1'b1;
    @(negedge clk);
    mc_word_en_in = 1'b0;
    roll_back     = 1'b0;
    rdy_in        = 1'b0;
    #1;
    expect_now("idle_req", {31'b0, mc_req_out}, 32'd0);
    probe("idle_w1", 32'h0000_0004);
    probe("idle_w2", 32'h0000_0008);

    // Conflict: same index, different tag replaces line 0
    do_fill(32'h0000_0400, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, -1, -1);
    probe("evicted", 32'h0000_0000);
    probe("new_w1", 32'h0000_0404);

    // Rollback mid-fill with a wandering fetch address
    do_fill(32'h0000_1230, {32'hC3C3_0003, 32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000}, 2, -1);
    probe("rb_w3", 32'h0000_123C);
    probe("rb_other", 32'h0000_0404);

    // rdy_in=0 stall during fill with mc_word_en_in high
    do_fill(32'h0000_2040, {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000}, -1, 2);
    probe("stall_w2", 32'h0000_2048);
    probe("stall_w1", 32'h0000_2044);

    // Asynchronous reset mid-fill
    @(negedge clk);
    rdy_in = 1'b1;
    probe("rst_fill_miss", 32'h0000_0000);
    @(negedge clk);
    #1;
    expect_now("rst_fill_req", {31'b0, mc_req_out}, 32'd1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      mc_word_en_in = 1'b1;
      mc_word_in    = 32'h7700_0000 + i;
      @(negedge clk);
    end
    mc_word_en_in = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    expect_now("async_rst_req", {31'b0, mc_req_out}, 32'd0);
    expect_now("async_rst_maddr", mc_addr_out, 32'h0);
    m_valid = '0;
    @(negedge clk);
    rdy_in = 1'b0;
    rst_in = 1'b1;
    probe("post_rst_0", 32'h0000_0000);
    probe("post_rst_404", 32'h0000_0404);
    probe("post_rst_1230", 32'h0000_1230);

    // Recovery after reset
    do_fill(32'h0000_0000, {32'h9999_0003, 32'h9999_0002, 32'h9999_0001, 32'h9999_0000}, -1, -1);
    probe("recover_w3", 32'h0000_000C);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
